// File: rtl/video_in_dma_sched.sv
// -----------------------------------------------------------------------------
// video_in_dma_sched
//
// Drains the capture FIFO into NB_BUF contiguous frame buffers in RAM over a
// wishbone master port. A locked write burst of BURST words starts only once
// the FIFO holds at least BURST words, so the FIFO can never underflow during
// a burst. Each word is popped (r_ack) on its bus ACK, and a one-cycle STB gap
// follows so that the show-ahead FIFO head can refresh. At the end of every
// frame the buffer index rotates and an interrupt is raised.
//
// Optional feature macro: VIDEO_IN_DMA_IRQ_LATCH_EN
//   undefined : interrupt is a one-cycle pulse in the frame-completing NEXT cycle
//   defined   : interrupt is a level, set at frame completion, cleared by
//               irq_ack (set wins over a simultaneous clear)
//
// Ports
//   clk, nRST            clock, asynchronous active-low reset
//   wb_reg_ctr           bit0 = enable
//   wb_reg_data          byte base address of buffer 0 (bits[1:0] ignored)
//   nb_pack_available    FIFO fill count, data_fifo = FIFO head word
//   r_ack                one-cycle FIFO pop
//   interrupt, irq_ack   end-of-frame interrupt and its clear
//   cur_buf              buffer currently being written
//   err                  sticky wishbone error flag
//   p_wb_*               wishbone master signals
//
// States
//   S_IDLE  | disabled, waiting for enable (restarts the frame at word 0)
//   S_WAIT  | enabled, waiting for BURST words in the FIFO
//   S_BUS   | locked burst in progress; STB alternates with gap cycles
//   S_NEXT  | one cycle after a burst; frame wrap and buffer rotation
//   S_FAULT | bus error seen; parked until enable is cleared
// -----------------------------------------------------------------------------
module video_in_dma_sched #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int NB_BUF  = 2,
    parameter int BURST   = 8,
    parameter int FIFO_AW = 5
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic [31:0]        wb_reg_ctr,
    input  logic [31:0]        wb_reg_data,
    input  logic [FIFO_AW:0]   nb_pack_available,
    input  logic [31:0]        data_fifo,
    output logic               r_ack,
    output logic               interrupt,
    input  logic               irq_ack,
    output logic [1:0]         cur_buf,
    output logic               err,
    output logic               p_wb_CYC_O,
    output logic               p_wb_STB_O,
    output logic               p_wb_LOCK_O,
    output logic [3:0]         p_wb_SEL_O,
    output logic [31:0]        p_wb_ADR_O,
    output logic [31:0]        p_wb_DAT_O,
    input  logic               p_wb_ACK_I,
    input  logic               p_wb_ERR_I
);

    localparam int FRAME_WORDS = IMG_W * IMG_H / 4;
    localparam int WIW         = $clog2(FRAME_WORDS + 1);
    localparam int BCW         = $clog2(BURST + 1);

    localparam logic [FIFO_AW:0] BURST_CNT   = BURST[FIFO_AW:0];
    localparam logic [BCW-1:0]   BURST_LAST  = BCW'(BURST - 1);
    localparam logic [WIW-1:0]   FRAME_LAST  = WIW'(FRAME_WORDS);
    localparam logic [1:0]       BUF_LAST    = 2'(NB_BUF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BUS,
        S_NEXT,
        S_FAULT
    } state_t;

    state_t         state_q, state_d;
    logic           stb_q, stb_d;
    logic [WIW-1:0] word_idx_q, word_idx_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]     cur_buf_q, cur_buf_d;
    logic [29:0]    base_q, base_d;
    logic           err_q, err_d;
    logic           irq_set;

    logic           enable;
    logic           ack_ok;
    logic           err_hit;
    logic           frame_done;
    logic [31:0]    word_off;
    logic           unused_bits;

    assign enable     = wb_reg_ctr[0];
    // ERR wins over a simultaneous ACK; ACK/ERR outside STB are ignored.
    assign err_hit    = stb_q && p_wb_ERR_I;
    assign ack_ok     = stb_q && p_wb_ACK_I && !p_wb_ERR_I;
    assign frame_done = (state_q == S_NEXT) && (word_idx_q == FRAME_LAST);
    assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0], irq_ack};

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            stb_q       <= 1'b0;
            word_idx_q  <= '0;
            burst_cnt_q <= '0;
            cur_buf_q   <= 2'd0;
            base_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            word_idx_q  <= word_idx_d;
            burst_cnt_q <= burst_cnt_d;
            cur_buf_q   <= cur_buf_d;
            base_q      <= base_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        word_idx_d  = word_idx_q;
        burst_cnt_d = burst_cnt_q;
        cur_buf_d   = cur_buf_q;
        base_d      = base_q;
        err_d       = err_q;
        irq_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                stb_d = 1'b0;
                if (enable) begin
                    state_d    = S_WAIT;
                    word_idx_d = '0;
                    base_d     = wb_reg_data[31:2];
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (nb_pack_available >= BURST_CNT) begin
                    state_d     = S_BUS;
                    stb_d       = 1'b1;
                    burst_cnt_d = '0;
                end
            end
            S_BUS: begin
                if (err_hit) begin
                    state_d = S_FAULT;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (ack_ok) begin
                    stb_d       = 1'b0;
                    word_idx_d  = word_idx_q + WIW'(1);
                    burst_cnt_d = burst_cnt_q + BCW'(1);
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d = S_NEXT;
                    end
                end else if (!stb_q) begin
                    // gap cycle over: FIFO head now shows the next word
                    stb_d = 1'b1;
                end
            end
            S_NEXT: begin
                if (frame_done) begin
                    word_idx_d = '0;
                    cur_buf_d  = (cur_buf_q == BUF_LAST) ? 2'd0 : cur_buf_q + 2'd1;
                    irq_set    = 1'b1;
                end
                if (enable) begin
                    state_d = S_WAIT;
                    // a new frame starts here, so pick up the current base
                    if (frame_done) begin
                        base_d = wb_reg_data[31:2];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                stb_d = 1'b0;
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

`ifdef VIDEO_IN_DMA_IRQ_LATCH_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign interrupt = irq_q;
`else
    assign interrupt = irq_set;
`endif

    assign word_off = 32'(cur_buf_q) * 32'(FRAME_WORDS) + 32'(word_idx_q);

    assign r_ack       = (state_q == S_BUS) && ack_ok;
    assign cur_buf     = cur_buf_q;
    assign err         = err_q;
    assign p_wb_CYC_O  = (state_q == S_BUS);
    assign p_wb_LOCK_O = (state_q == S_BUS);
    assign p_wb_STB_O  = stb_q;
    assign p_wb_SEL_O  = stb_q ? 4'hF : 4'h0;
    assign p_wb_DAT_O  = stb_q ? data_fifo : 32'h0;
    assign p_wb_ADR_O  = {base_q, 2'b00} + {word_off[29:0], 2'b00};

endmodule

// File: tb/tb_video_in_dma_sched.sv
module tb_video_in_dma_sched;

    localparam logic [31:0] DATA0 = 32'hA5000000;

    logic        clk;
    logic        rst_n;
    logic [31:0] wb_reg_ctr;
    logic [31:0] wb_reg_data;
    logic [5:0]  fifo_cnt;
    logic [31:0] head;
    logic        r_ack;
    logic        interrupt;
    logic        irq_ack;
    logic [1:0]  cur_buf;
    logic        err;
    logic        cyc, stb, lock;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack, berr;

    video_in_dma_sched #(
        .IMG_W(8), .IMG_H(4), .NB_BUF(2), .BURST(4), .FIFO_AW(5)
    ) dut (
        .clk(clk), .nRST(rst_n),
        .wb_reg_ctr(wb_reg_ctr), .wb_reg_data(wb_reg_data),
        .nb_pack_available(fifo_cnt), .data_fifo(head),
        .r_ack(r_ack), .interrupt(interrupt), .irq_ack(irq_ack),
        .cur_buf(cur_buf), .err(err),
        .p_wb_CYC_O(cyc), .p_wb_STB_O(stb), .p_wb_LOCK_O(lock),
        .p_wb_SEL_O(sel), .p_wb_ADR_O(adr), .p_wb_DAT_O(dat),
        .p_wb_ACK_I(ack), .p_wb_ERR_I(berr)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        bit          is_err;
    } exp_t;

    exp_t exp_q[$];
    int   irq_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int exp_pop  = 0;
    int rack_total = 0;
    int ack_words  = 0;
    int age = 0;
    bit irq_prev = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push_words(input logic [31:0] a0, input int n, input int err_at);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.adr    = a0 + 32'(4 * i);
            e.dat    = DATA0 + 32'(exp_pop);
            e.is_err = (i == err_at);
            exp_q.push_back(e);
            if (!e.is_err) exp_pop++;
        end
    endtask

    // wishbone slave + scoreboard monitor: ACK/ERR in the 2nd cycle of STB
    always @(negedge clk) begin
        exp_t e;
        if (stb !== 1'b1) begin
            age  = 0;
            ack  = 0;
            berr = 0;
        end else if (ack || berr) begin
            age  = 0;
            ack  = 0;
            berr = 0;
        end else begin
            age++;
            if (age >= 2) begin
                age = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_write: got adr %h want no write", adr);
                    ack = 1;
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err) berr = 1;
                    else          ack  = 1;
                    #1;
                    chk("adr", adr, e.adr);
                    chk("dat", dat, e.dat);
                    chk("sel", {28'd0, sel}, 32'hF);
                    chk("cyc_lock", {30'd0, cyc, lock}, 32'h3);
                    chk("r_ack", {31'd0, r_ack}, {31'd0, !e.is_err});
                    if (r_ack === 1'b1) begin
                        rack_total++;
                        head = head + 1;
                        if (fifo_cnt != 0) fifo_cnt = fifo_cnt - 1;
                    end
                    if (!e.is_err) ack_words++;
                end
            end
        end
    end

    // interrupt monitor: each rising edge must match the next expected frame end
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (interrupt === 1'b1 && !irq_prev) begin
                if (irq_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_irq: got irq at word %0d want none", ack_words);
                end else begin
                    chk("irq_word", 32'(ack_words), 32'(irq_q.pop_front()));
                end
            end
            irq_prev = (interrupt === 1'b1);
        end
    end

    task automatic drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic await_irq(input int budget);
        int c = 0;
        while (irq_q.size() != 0 && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (irq_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL irq_timeout: got %0d pending want 0", irq_q.size());
            irq_q.delete();
        end
`ifdef VIDEO_IN_DMA_IRQ_LATCH_EN
        repeat (3) @(negedge clk);
        #2;
        chk("irq_level_held", {31'd0, interrupt}, 32'd1);
        irq_ack = 1;
        @(negedge clk);
        irq_ack = 0;
        #2;
        chk("irq_cleared", {31'd0, interrupt}, 32'd0);
`else
        chk("irq_pulse_ended", {31'd0, interrupt}, 32'd0);
`endif
    endtask

    initial begin
        int cyc_seen;
        int rack0;
        int c;
        rst_n       = 0;
        wb_reg_ctr  = 0;
        wb_reg_data = 0;
        fifo_cnt    = 0;
        head        = DATA0;
        ack         = 0;
        berr        = 0;
        irq_ack     = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bus", {cyc, stb, lock, sel, r_ack, interrupt, err}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_dat", dat, 32'd0);
        chk("rst_buf", {30'd0, cur_buf}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // 1: first burst, base low bits ignored
        @(negedge clk);
        push_words(32'h1000, 4, -1);
        wb_reg_data = 32'h0000_1003;
        fifo_cnt    = 4;
        wb_reg_ctr  = 32'h1;
        drain(100);
        chk("t1_cyc_after", {31'd0, cyc}, 32'd0);
        chk("t1_racks", 32'(rack_total), 32'd4);

        // 2: below threshold holds off, threshold starts one cycle later
        fifo_cnt = 3;
        cyc_seen = 0;
        repeat (6) begin
            @(negedge clk);
            #2;
            if (cyc === 1'b1) cyc_seen++;
        end
        chk("t2_no_cyc", 32'(cyc_seen), 32'd0);
        push_words(32'h1010, 4, -1);
        irq_q.push_back(8);
        @(negedge clk);
        fifo_cnt = 4;
        @(negedge clk);
        #2;
        chk("t2_start", {30'd0, cyc, stb}, 32'h3);
        drain(100);
        await_irq(20);
        chk("t2_buf", {30'd0, cur_buf}, 32'd1);

        // 3: second buffer then wrap to the first
        push_words(32'h1020, 8, -1);
        irq_q.push_back(16);
        fifo_cnt = 8;
        drain(200);
        await_irq(20);
        chk("t3_buf", {30'd0, cur_buf}, 32'd0);
        push_words(32'h1000, 4, -1);
        fifo_cnt = 4;
        drain(100);

        // 4: bus error on 2nd word
        rack0 = rack_total;
        push_words(32'h1010, 2, 1);
        fifo_cnt = 4;
        drain(100);
        chk("t4_cyc_err", {30'd0, cyc, err}, 32'h1);
        chk("t4_racks", 32'(rack_total - rack0), 32'd1);
        wb_reg_ctr = 0;
        repeat (3) @(negedge clk);

        // 5: restart at word 0, enable dropped on 2nd ACK
        push_words(32'h1000, 4, -1);
        rack0      = rack_total;
        fifo_cnt   = 8;
        wb_reg_ctr = 32'h1;
        c = 0;
        while (rack_total < rack0 + 2 && c < 100) begin
            @(negedge clk);
            #2;
            c++;
        end
        wb_reg_ctr = 0;
        chk("t5_drop_point", 32'(rack_total - rack0), 32'd2);
        drain(100);
        repeat (6) @(negedge clk);
        #2;
        chk("t5_idle", {30'd0, cyc, err}, 32'h1);
        chk("t5_fifo_left", {26'd0, fifo_cnt}, 32'd4);
        push_words(32'h1000, 8, -1);
        irq_q.push_back(33);
        fifo_cnt   = 8;
        wb_reg_ctr = 32'h1;
        drain(200);
        await_irq(20);
        chk("t5_buf", {30'd0, cur_buf}, 32'd1);

`ifdef VIDEO_IN_DMA_IRQ_LATCH_EN
        // 6: level held until acked; ack coincident with frame end loses
        push_words(32'h1020, 8, -1);
        irq_q.push_back(41);
        fifo_cnt = 8;
        drain(200);
        repeat (5) @(negedge clk);
        #2;
        chk("t6_held", {31'd0, interrupt}, 32'd1);
        push_words(32'h1000, 8, -1);
        fifo_cnt = 8;
        c = 0;
        while (ack_words < 49 && c < 200) begin
            @(negedge clk);
            #2;
            c++;
        end
        @(posedge clk);
        #1;
        irq_ack = 1;
        @(posedge clk);
        #1;
        irq_ack = 0;
        chk("t6_set_wins", {31'd0, interrupt}, 32'd1);
        chk("t6_buf", {30'd0, cur_buf}, 32'd1);
        drain(50);
        irq_ack = 1;
        @(negedge clk);
        irq_ack = 0;
        #2;
        chk("t6_cleared", {31'd0, interrupt}, 32'd0);
`endif

        chk("left_writes", 32'(exp_q.size()), 32'd0);
        chk("left_irqs", 32'(irq_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
